// File: rtl/arb1hot_rr.sv
// rtl/arb1hot_rr.sv - round-robin arbiter with registered one-hot grant held until done
// Optional macro ARB1HOT_PARK_EN: gnt parks on last winner while idle, resets to bit 0.
module arb1hot_rr #(
   parameter int N    = 8,
   parameter int IDXW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx
);

   typedef enum logic {IDLE, GRANT} state_t;

`ifdef ARB1HOT_PARK_EN
   localparam logic [N-1:0] GNT_RST = {{(N-1){1'b0}}, 1'b1};
   localparam bit           PARK    = 1'b1;
`else
   localparam logic [N-1:0] GNT_RST = '0;
   localparam bit           PARK    = 1'b0;
`endif

   state_t          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic            gnt_valid_q, gnt_valid_d;

   logic [IDXW-1:0] base;
   logic [IDXW-1:0] win_idx;
   logic            found;

   // On completion the search starts just past the current winner, so it ranks last.
   always_comb begin
      int j;
      j       = 0;
      base    = ptr_q;
      if (state_q == GRANT && done) begin
         base = (gnt_idx_q == IDXW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
      end
      found   = 1'b0;
      win_idx = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(base) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found   = 1'b1;
            win_idx = IDXW'(j);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_idx;
               gnt_idx_d   = win_idx;
               gnt_valid_d = 1'b1;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (done) begin
               ptr_d = base;
               if (found) begin
                  gnt_d     = {{(N-1){1'b0}}, 1'b1} << win_idx;
                  gnt_idx_d = win_idx;
               end else begin
                  gnt_valid_d = 1'b0;
                  state_d     = IDLE;
                  if (!PARK) gnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_q       <= GNT_RST;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_arb1hot_rr.sv
// tb/tb_arb1hot_rr.sv - directed and random checks of arb1hot_rr against a round-robin model
module tb_arb1hot_rr;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic         done = 1'b0;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [2:0]   gnt_idx;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef ARB1HOT_PARK_EN
   localparam bit PARK = 1'b1;
`else
   localparam bit PARK = 1'b0;
`endif

   // Reference state: pointer, busy flag, current winner, expected grant vector.
   int           m_ptr  = 0;
   bit           m_busy = 1'b0;
   int           m_idx  = 0;
   logic [N-1:0] m_gnt  = PARK ? 8'h01 : 8'h00;

   arb1hot_rr #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
      int w;
      if (rs) begin
         m_busy = 1'b0; m_idx = 0; m_ptr = 0;
         m_gnt  = PARK ? 8'h01 : 8'h00;
      end else if (!m_busy) begin
         if (r != 0) begin
            w = pick(r, m_ptr);
            m_idx = w; m_busy = 1'b1; m_gnt = 8'h01 << w;
         end
      end else if (d) begin
         m_ptr = (m_idx + 1) % N;
         if (r != 0) begin
            w = pick(r, m_ptr);
            m_idx = w; m_gnt = 8'h01 << w;
         end else begin
            m_busy = 1'b0;
            if (!PARK) m_gnt = '0;
         end
      end
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic d, input logic rs);
      req = r; done = d; rst = rs;
      @(posedge clk);
      model_step(r, d, rs);
      #1;
      check_eq("model_gnt", 32'(gnt), 32'(m_gnt));
      check_eq("model_valid", 32'(gnt_valid), 32'(m_busy));
      check_eq("model_idx", 32'(gnt_idx), 32'(m_idx));
      check_eq("onehot", 32'($countones(gnt) <= 1), 32'd1);
   endtask

   initial begin
      cycle(8'hFF, 1'b0, 1'b1);
      cycle(8'hFF, 1'b0, 1'b1);
      check_eq("rst_valid", 32'(gnt_valid), 32'd0);
      check_eq("rst_gnt", 32'(gnt), PARK ? 32'h01 : 32'h00);
      check_eq("rst_idx", 32'(gnt_idx), 32'd0);

      cycle(8'h10, 1'b0, 1'b0);
      check_eq("single_gnt", 32'(gnt), 32'h10);
      check_eq("single_idx", 32'(gnt_idx), 32'd4);
      check_eq("single_valid", 32'(gnt_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         cycle(8'h00, 1'b0, 1'b0);
         check_eq("hold_gnt", 32'(gnt), 32'h10);
      end

      cycle(8'h00, 1'b1, 1'b0);
      check_eq("drain_valid", 32'(gnt_valid), 32'd0);
      check_eq("drain_gnt", 32'(gnt), PARK ? 32'h10 : 32'h00);
      cycle(8'h00, 1'b1, 1'b0);
      check_eq("idle_done_valid", 32'(gnt_valid), 32'd0);
      check_eq("idle_done_idx", 32'(gnt_idx), 32'd4);

      cycle(8'hFF, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) begin
         cycle(8'hFF, 1'b1, 1'b0);
         check_eq("rot_gnt", 32'(gnt), 32'h01 << (k % 8));
         check_eq("rot_valid", 32'(gnt_valid), 32'd1);
      end
      for (int k = 0; k < 6; k++) cycle(8'hFF, 1'b1, 1'b0);
      check_eq("reach6_gnt", 32'(gnt), 32'h40);
      cycle(8'h41, 1'b1, 1'b0);
      check_eq("skip_gnt", 32'(gnt), 32'h01);
      cycle(8'h41, 1'b1, 1'b0);
      check_eq("wrap_gnt", 32'(gnt), 32'h40);

      cycle(8'h00, 1'b0, 1'b1);
      cycle(8'h08, 1'b0, 1'b0);
      cycle(8'h08, 1'b0, 1'b0);
      check_eq("mid_gnt", 32'(gnt), 32'h08);
      cycle(8'hFF, 1'b1, 1'b1);
      check_eq("mid_rst_valid", 32'(gnt_valid), 32'd0);
      cycle(8'h0C, 1'b0, 1'b0);
      check_eq("post_rst_gnt", 32'(gnt), 32'h04);

      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] r;
         r = N'($urandom);
         if ($urandom_range(0, 3) == 0) r = '0;
         if ($urandom_range(0, 3) == 0) r = N'(1) << $urandom_range(0, N - 1);
         cycle(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
